jogador_automatico: RTL
=======================

# jogador_automatico

Automatic player for the memory game: drives the game's `jogar` and `botoes` inputs, and watches its `leds`, `pronto`, `ganhou` and `perdeu` outputs. Each round it records the sequence the game displays, then replays it on the buttons with fixed press/release timing. It sits beside the game top level on the same clock, for unattended board demos and closed-loop benches.

## Interface
- `T_SILENCIO`, default 200: consecutive cycles of `leds == 0` that end a display phase.
- `T_PRESS`, default 10: cycles a replayed button is held.
- `T_SOLTA`, default 10: cycles all buttons are released between replayed steps.
- `MAX_PASSOS`, default 16: sequence memory depth.
- `clock`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-high.
- `habilita`  in  1  level; high starts a game, low after end returns to idle.
- `leds`  in  3  game LED code: 0 is off, 1..4 mean button 0..3, 5..7 are invalid.
- `pronto`  in  1  game finished.
- `ganhou`  in  1  game result: win.
- `perdeu`  in  1  game result: loss.
- `jogar`  out  1  one-cycle start pulse to the game.
- `botoes`  out  4  one-hot button press, or 0.
- `venceu`  out  1  latched win flag.
- `erro_captura`  out  1  latched: invalid code or overflow seen.
- `db_tamanho`  out  4  steps captured this round, minus 1.
- `db_estado`  out  5  state code.

## Operation
- States and codes:
  - `INICIAL` 0
  - `PULSO` 1
  - `ESPERA_LED` 2
  - `LED_ACESO` 3
  - `SILENCIO` 4
  - `PRESSIONA` 5
  - `SOLTA` 6
  - `FIM` 7
- `INICIAL`: `botoes`=0. When `habilita`=1, go to `PULSO` and clear `venceu` and `erro_captura`.
- `PULSO`: `jogar`=1 for exactly one cycle. Clear the write index, then go to `ESPERA_LED`.
- `ESPERA_LED`: wait for `leds != 0`. On that cycle, store the code into memory at the write index, increment the index, and go to `LED_ACESO`. There is no timeout before the first step.
- `LED_ACESO`: wait for `leds == 0`, then go to `SILENCIO`. Steps are counted on off-to-on transitions only.
- `SILENCIO`: count consecutive cycles with `leds == 0`.
  - `leds != 0`: capture the step, go to `LED_ACESO`, clear the counter.
  - Counter reaches `T_SILENCIO`: round length = write index. Clear the read index and go to `PRESSIONA`.
- `PRESSIONA`: `botoes = 1 << (mem[rd] - 1)` for `T_PRESS` cycles, then go to `SOLTA`.
- `SOLTA`: `botoes`=0 for `T_SOLTA` cycles, then increment the read index.
  - Read index equals the round length: clear the write index, go to `ESPERA_LED`.
  - Otherwise: go to `PRESSIONA`.
- `leds` is ignored in `PRESSIONA` and `SOLTA`, because the game echoes the pressed button on the LEDs.
- `pronto`=1 in any state other than `INICIAL` forces `FIM` on the next edge. `botoes` drops to 0 and `venceu` latches `ganhou`.
- `FIM`: stay until `habilita`=0, then go to `INICIAL`.
- Invalid code (5..7) on capture: do not store it, set `erro_captura`, treat the LED as lit.
- Capture with write index = `MAX_PASSOS`: do not store it, set `erro_captura`.
- `db_tamanho` = write index − 1, saturating at 0.

## Timing
- Reset value of all outputs is 0; state is `INICIAL`; both indices are 0.
- `leds` is sampled directly. It comes from the same clock domain, so there is no synchronizer.
- `jogar` rises exactly 1 cycle after `habilita` is first sampled high in `INICIAL`.
- Capture latency: the step is stored on the first edge where `leds != 0`.
- Replay of step 0 starts exactly `T_SILENCIO` cycles after the last LED went off.
- Step period during replay is `T_PRESS + T_SOLTA` cycles.
- `pronto` has priority over every other transition in the same cycle.
- Asynchronous reset mid-replay releases `botoes` immediately, with no clock needed.

## Configuration
- `JOGADOR_ERRO_EN` defined: adds input `errar` (1 bit). When `errar`=1 while the last step of a round is replayed, the player presses button `(idx+1) mod 4` instead of `idx`. Used to exercise the loss path.
- Not defined: there is no `errar` port and replay is always exact.

## Structure
- Shared package holds:
  - State codes.
  - LED code constants (`LED_APAGADO`=0, `LED_MAX`=4).
  - A function mapping a code to one-hot `botoes`.
- One sub-module, `memoria_passos`: `MAX_PASSOS` x 3-bit register file with synchronous write and combinational read.
- The FSM and the three counters (silence, press/release, indices) stay in `jogador_automatico`.

## Test plan
Bench parameters: `T_SILENCIO`=8, `T_PRESS`=3, `T_SOLTA`=2.
- Start: `habilita` rises at cycle 5 -> `jogar` is high only in cycle 6, `db_estado`=2 in cycle 7.
- One-step round: `leds`=3 for 4 cycles, then 0 -> `botoes`=4'b0100 for 3 cycles, beginning 8 cycles after the LED went off, then 0.
- Three-step round: `leds` shows 1, 4, 2 with gaps of 2 -> `botoes` = 0001, 1000, 0010, each held 3 cycles with 2-cycle gaps, and `db_tamanho`=2.
- Invalid/overflow: `leds`=6 -> `erro_captura`=1 and that step is not replayed. 17 steps shown -> `erro_captura`=1 and 16 steps are replayed.
- End: `pronto`=1 with `ganhou`=1 during `PRESSIONA` -> `botoes`=0 the next cycle, `venceu`=1, state 7. `habilita`=0 -> state 0.
- Reset mid-`PRESSIONA` -> `botoes`=0 with no clock edge, and all outputs are 0.

Source files
------------

// File: rtl/jogador_automatico_pkg.sv
// Shared state codes, LED codes and button helper for the automatic player.
package jogador_automatico_pkg;

  typedef enum logic [4:0] {
    INICIAL    = 5'd0,
    PULSO      = 5'd1,
    ESPERA_LED = 5'd2,
    LED_ACESO  = 5'd3,
    SILENCIO   = 5'd4,
    PRESSIONA  = 5'd5,
    SOLTA      = 5'd6,
    FIM        = 5'd7
  } estado_t;

  localparam logic [2:0] LED_APAGADO = 3'd0;
  localparam logic [2:0] LED_MAX     = 3'd4;

  // Code 0 shifts the bit out, so it maps to no button.
  function automatic logic [3:0] botao_de(input logic [2:0] codigo);
    botao_de = 4'b0001 << (codigo - 3'd1);
  endfunction

endpackage

// File: rtl/jogador_automatico_memoria_passos.sv
// Step memory: synchronous write, combinational read.
module memoria_passos
  import jogador_automatico_pkg::*;
#(
  parameter int MAX_PASSOS = 16,
  parameter int AW = 4
) (
  input  logic          clock,
  input  logic          we,
  input  logic [AW-1:0] wr_addr,
  input  logic [2:0]    wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [2:0]    rd_data
);

  logic [2:0] mem [MAX_PASSOS];

  always_ff @(posedge clock) begin
    if (we) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/jogador_automatico.sv
// Automatic memory-game player: records each displayed round, replays it.
// Optional JOGADOR_ERRO_EN adds input errar to miss the last step on purpose.
module jogador_automatico
  import jogador_automatico_pkg::*;
#(
  parameter int T_SILENCIO = 200,
  parameter int T_PRESS    = 10,
  parameter int T_SOLTA    = 10,
  parameter int MAX_PASSOS = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       habilita,
  input  logic [2:0] leds,
  input  logic       pronto,
  input  logic       ganhou,
  input  logic       perdeu,
`ifdef JOGADOR_ERRO_EN
  input  logic       errar,
`endif
  output logic       jogar,
  output logic [3:0] botoes,
  output logic       venceu,
  output logic       erro_captura,
  output logic [3:0] db_tamanho,
  output logic [4:0] db_estado
);

  localparam int IW = $clog2(MAX_PASSOS + 1);
  localparam int AW = (MAX_PASSOS > 1) ? $clog2(MAX_PASSOS) : 1;
  localparam int SW = $clog2(T_SILENCIO + 1);
  localparam int TM = (T_PRESS > T_SOLTA) ? T_PRESS : T_SOLTA;
  localparam int TW = $clog2(TM + 1);

  localparam logic [IW-1:0] UM        = IW'(1);
  localparam logic [IW-1:0] CHEIO     = IW'(MAX_PASSOS);
  localparam logic [SW-1:0] SIL_FIM   = SW'(T_SILENCIO - 1);
  localparam logic [TW-1:0] PRESS_FIM = TW'(T_PRESS);
  localparam logic [TW-1:0] SOLTA_FIM = TW'(T_SOLTA);

  estado_t       estado;
  logic [IW-1:0] wr_idx;
  logic [IW-1:0] rd_idx;
  logic [IW-1:0] len;
  logic [SW-1:0] sil_cnt;
  logic [TW-1:0] tmr;

  logic          acende;
  logic          valido;
  logic          cheio;
  logic          captura;
  logic          we;
  logic [IW-1:0] rd_prox;
  logic [AW-1:0] rd_addr;
  logic [2:0]    rd_data;
  logic [3:0]    botao_reg;
  logic [3:0]    botao_sel;

  assign acende  = leds != LED_APAGADO;
  assign valido  = leds <= LED_MAX;
  assign cheio   = wr_idx == CHEIO;
  assign captura = acende && !pronto &&
                   (estado == ESPERA_LED || estado == SILENCIO);
  assign we      = captura && valido && !cheio;
  assign rd_prox = rd_idx + UM;
  // Address of the step about to be pressed: 0 on replay start.
  assign rd_addr = (estado == SILENCIO) ? '0 : AW'(rd_prox);
  assign botao_reg = botao_de(rd_data);

`ifdef JOGADOR_ERRO_EN
  logic [IW-1:0] alvo;
  logic          ultimo;
  assign alvo   = (estado == SILENCIO) ? wr_idx : len;
  assign ultimo = rd_addr == AW'(alvo - UM);
  assign botao_sel = (errar && ultimo) ?
                     {botao_reg[2:0], botao_reg[3]} : botao_reg;
`else
  assign botao_sel = botao_reg;
`endif

  memoria_passos #(
    .MAX_PASSOS(MAX_PASSOS),
    .AW(AW)
  ) u_mem (
    .clock(clock),
    .we(we),
    .wr_addr(wr_idx[AW-1:0]),
    .wr_data(leds),
    .rd_addr(rd_addr),
    .rd_data(rd_data)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado       <= INICIAL;
      wr_idx       <= '0;
      rd_idx       <= '0;
      len          <= '0;
      sil_cnt      <= '0;
      tmr          <= '0;
      jogar        <= 1'b0;
      botoes       <= '0;
      venceu       <= 1'b0;
      erro_captura <= 1'b0;
    end else if (pronto && estado != INICIAL) begin
      estado <= FIM;
      jogar  <= 1'b0;
      botoes <= '0;
      venceu <= ganhou & ~perdeu;
    end else begin
      jogar <= 1'b0;
      unique case (estado)
        INICIAL: begin
          botoes <= '0;
          if (habilita) begin
            estado       <= PULSO;
            jogar        <= 1'b1;
            venceu       <= 1'b0;
            erro_captura <= 1'b0;
          end
        end
        PULSO: begin
          wr_idx <= '0;
          estado <= ESPERA_LED;
        end
        ESPERA_LED: begin
          if (captura) begin
            if (!valido || cheio) erro_captura <= 1'b1;
            else wr_idx <= wr_idx + UM;
            estado <= LED_ACESO;
          end
        end
        LED_ACESO: begin
          if (!acende) begin
            sil_cnt <= SW'(1);
            estado  <= SILENCIO;
          end
        end
        SILENCIO: begin
          if (captura) begin
            if (!valido || cheio) erro_captura <= 1'b1;
            else wr_idx <= wr_idx + UM;
            sil_cnt <= '0;
            estado  <= LED_ACESO;
          end else if (sil_cnt == SIL_FIM) begin
            len    <= wr_idx;
            rd_idx <= '0;
            if (wr_idx == '0) begin
              estado <= ESPERA_LED;
            end else begin
              botoes <= botao_sel;
              tmr    <= TW'(1);
              estado <= PRESSIONA;
            end
          end else begin
            sil_cnt <= sil_cnt + SW'(1);
          end
        end
        PRESSIONA: begin
          if (tmr == PRESS_FIM) begin
            botoes <= '0;
            tmr    <= TW'(1);
            estado <= SOLTA;
          end else begin
            tmr <= tmr + TW'(1);
          end
        end
        SOLTA: begin
          if (tmr == SOLTA_FIM) begin
            rd_idx <= rd_prox;
            if (rd_prox == len) begin
              wr_idx <= '0;
              estado <= ESPERA_LED;
            end else begin
              botoes <= botao_sel;
              tmr    <= TW'(1);
              estado <= PRESSIONA;
            end
          end else begin
            tmr <= tmr + TW'(1);
          end
        end
        FIM: begin
          if (!habilita) estado <= INICIAL;
        end
        default: estado <= INICIAL;
      endcase
    end
  end

  assign db_estado  = estado;
  assign db_tamanho = (wr_idx == '0) ? 4'd0 : 4'(wr_idx - UM);

endmodule
